// File: rtl/areg_pkg.sv
// Shared types and sizes for the areg read-side sequencer.
package areg_pkg;

    localparam int IDX_W = 4;
    localparam int CNT_W = 5;
    localparam int NREG  = 16;

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] reg_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/areg_rd_stage.sv
// Output holding register for the areg reader: one beat of (idx, value, last)
// held stable under back-pressure until the consumer takes it.
module areg_rd_stage
    import areg_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             consume,
    input  logic [3:0]       load_idx,
    input  logic [W-1:0]     load_val,
    input  logic             load_last,
    output logic             out_valid,
    output logic [3:0]       out_idx,
    output logic [W-1:0]     out_val,
    output logic             out_last
);

    // A reload takes priority; a consumed beat with no reload empties the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_val   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_idx   <= load_idx;
            out_val   <= load_val;
            out_last  <= load_last;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/areg_reader.sv
// Read-side sequencer for the 16-entry areg file: walks a (first, count) burst
// over the file's read port and streams (idx, value) beats with ready/valid.
module areg_reader
    import areg_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_first,
    input  logic [4:0]   req_count,
    output logic [3:0]   ra,
    input  logic [W-1:0] rval,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_idx,
    output logic [W-1:0] out_val,
    output logic         out_last,
    output logic         done
);

    rd_state_t state_q;
    rd_state_t state_d;
    reg_idx_t  ptr;
    reg_cnt_t  rem;
    logic      accept;
    logic      load;
    logic      consume;
    logic      finish;

    assign ra      = ptr;
    assign consume = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        load      = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid && (req_count != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                load = (rem != '0) && (!out_valid || out_ready);
                if (load && (rem == 5'd1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (consume) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A zero-length request completes immediately without producing beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= '0;
            rem  <= '0;
            done <= 1'b0;
        end else begin
            done <= (accept && (req_count == '0)) || finish;
            if (accept) begin
                ptr <= req_first;
                rem <= req_count;
            end else if (load) begin
                ptr <= ptr + 4'd1;
                rem <= rem - 5'd1;
            end
        end
    end

    areg_rd_stage #(
        .W(W)
    ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .consume   (consume),
        .load_idx  (ptr),
        .load_val  (rval),
        .load_last (rem == 5'd1),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_val   (out_val),
        .out_last  (out_last)
    );

endmodule
